spike_window_classifier: RTL and testbench

SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

---
 rtl/snn_cls_pkg.sv | 19 +
 rtl/spike_counter.sv | 39 +++
 rtl/spike_window_classifier.sv | 134 +++++++++++++
 tb/tb_spike_window_classifier.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_cls_pkg.sv
// Shared types and default sizing for the spike-window classifier.
// Optional tie flag output on the top is enabled by defining SPK_TIE_FLAG_EN.
package snn_cls_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COUNT  = 2'd2,
      ST_REPORT = 2'd3
   } cls_state_e;

   localparam int WINDOW_DEF = 15;
   localparam int SETTLE_DEF = 2;
   localparam int CNT_W_DEF  = 8;

   // Phase counter must cover the longest phase (WINDOW up to 255).
   localparam int PHASE_W = 8;

endpackage

// File: rtl/spike_counter.sv
// One saturating spike counter: synchronous clear wins over increment,
// and the value sticks at all-ones instead of wrapping.
module spike_counter
   import snn_cls_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_window_classifier.sv
// Drives a spiking network through settle/count windows and reports which of
// output neurons 0 and 1 fired more. Define SPK_TIE_FLAG_EN to add res_tie.
//
// Result handshake: res_valid rises on REPORT entry and holds, together with
// res_label/res_cnt, until a cycle where res_valid && res_ready; the result is
// consumed on that rising edge and res_valid drops on the following cycle.
module spike_window_classifier
   import snn_cls_pkg::*;
#(
   parameter int N_OUT  = 2,
   parameter int WINDOW = WINDOW_DEF,
   parameter int SETTLE = SETTLE_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   run,
   input  logic [N_OUT-1:0]       spk_in,
   output logic                   net_reset,
   output logic                   example_req,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   res_label,
   output logic [N_OUT*CNT_W-1:0] res_cnt,
`ifdef SPK_TIE_FLAG_EN
   output logic                   res_tie,
`endif
   output cls_state_e             dbg_state
);

   localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE - 1);
   localparam logic [PHASE_W-1:0] WINDOW_LAST = PHASE_W'(WINDOW - 1);

   cls_state_e         state_q;
   logic [PHASE_W-1:0] phase_q;
   logic               net_reset_q;
   logic               example_req_q;
   logic               res_valid_q;

   logic               cnt_clr;
   logic               cnt_en;
   logic [CNT_W-1:0]   cnt0;
   logic [CNT_W-1:0]   cnt1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         phase_q       <= '0;
         net_reset_q   <= 1'b1;
         example_req_q <= 1'b0;
         res_valid_q   <= 1'b0;
      end else begin
         example_req_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               net_reset_q <= 1'b1;
               if (run) begin
                  state_q       <= ST_SETTLE;
                  phase_q       <= '0;
                  example_req_q <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (phase_q == SETTLE_LAST) begin
                  state_q     <= ST_COUNT;
                  phase_q     <= '0;
                  net_reset_q <= 1'b0;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_COUNT: begin
               if (phase_q == WINDOW_LAST) begin
                  state_q     <= ST_REPORT;
                  phase_q     <= '0;
                  net_reset_q <= 1'b1;
                  res_valid_q <= 1'b1;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_REPORT: begin
               // run is only looked at here, so dropping it mid-example
               // lets the current example finish.
               if (res_valid_q && res_ready) begin
                  res_valid_q <= 1'b0;
                  phase_q     <= '0;
                  if (run) begin
                     state_q       <= ST_SETTLE;
                     example_req_q <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               phase_q     <= '0;
               net_reset_q <= 1'b1;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_clr = (state_q == ST_SETTLE) && (phase_q == '0);
   assign cnt_en  = (state_q == ST_COUNT);

   for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
      spike_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .clk_i   (clk),
         .reset_ni(reset_n),
         .clr_i   (cnt_clr),
         .inc_i   (cnt_en & spk_in[i]),
         .cnt_o   (res_cnt[CNT_W*i +: CNT_W])
      );
   end

   // Counters are frozen outside COUNT, so the gated compare is stable in REPORT.
   assign cnt0 = res_cnt[CNT_W-1:0];
   assign cnt1 = res_cnt[2*CNT_W-1:CNT_W];

   assign res_label   = res_valid_q & (cnt0 < cnt1);
`ifdef SPK_TIE_FLAG_EN
   assign res_tie     = res_valid_q & (cnt0 == cnt1);
`endif
   assign net_reset   = net_reset_q;
   assign example_req = example_req_q;
   assign res_valid   = res_valid_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed bench for spike_window_classifier: a default instance plus a
// CNT_W=2 instance run in lockstep on shared stimulus.
module tb_spike_window_classifier;
   import snn_cls_pkg::*;

   localparam int WINDOW = 15;
   localparam int SETTLE = 2;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic        run       = 1'b0;
   logic        res_ready = 1'b0;
   logic [1:0]  spk_in    = 2'b00;

   logic        net_reset, example_req, res_valid, res_label;
   logic [15:0] res_cnt;
   cls_state_e  dbg_state;

   logic        net_reset_w2, example_req_w2, res_valid_w2, res_label_w2;
   logic [3:0]  res_cnt_w2;
   cls_state_e  dbg_state_w2;
`ifdef SPK_TIE_FLAG_EN
   logic        res_tie, res_tie_w2;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          req_cyc = -1;
   int          prev_req_cyc = -1;
   logic [1:0]  win_pat [WINDOW];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spike_window_classifier dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (run),
      .spk_in     (spk_in),
      .net_reset  (net_reset),
      .example_req(example_req),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_label  (res_label),
      .res_cnt    (res_cnt),
`ifdef SPK_TIE_FLAG_EN
      .res_tie    (res_tie),
`endif
      .dbg_state  (dbg_state)
   );

   spike_window_classifier #(.CNT_W(2)) dut_w2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (run),
      .spk_in     (spk_in),
      .net_reset  (net_reset_w2),
      .example_req(example_req_w2),
      .res_valid  (res_valid_w2),
      .res_ready  (res_ready),
      .res_label  (res_label_w2),
      .res_cnt    (res_cnt_w2),
`ifdef SPK_TIE_FLAG_EN
      .res_tie    (res_tie_w2),
`endif
      .dbg_state  (dbg_state_w2)
   );

   task automatic wait_req();
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (example_req === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL example_req_timeout: got no pulse within 40 cycles, want a pulse");
      end
      prev_req_cyc = req_cyc;
      req_cyc = cyc;
   endtask

   // Leaves the caller at the negedge inside the REPORT cycle.
   task automatic run_example(input logic [1:0] settle_pat, input int drop_run_at,
                              input logic ready_val);
      wait_req();
      res_ready = ready_val;
      n_cmp++;
      if (net_reset !== 1'b1) begin
         n_bad++;
         $display("FAIL settle_net_reset: got %b, want 1", net_reset);
      end
      spk_in = settle_pat;
      for (int s = 1; s < SETTLE; s++) begin
         @(negedge clk);
         spk_in = settle_pat;
      end
      for (int i = 0; i < WINDOW; i++) begin
         @(negedge clk);
         n_cmp++;
         if (net_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL count_net_reset: cycle %0d got %b, want 0", i, net_reset);
         end
         if (i == drop_run_at) run = 1'b0;
         spk_in = win_pat[i];
      end
      @(negedge clk);
      spk_in = 2'b00;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; run = 1'b0; res_ready = 1'b0; spk_in = 2'b00;
      repeat (2) @(negedge clk);
      n_cmp++; if (net_reset !== 1'b1) begin n_bad++; $display("FAIL reset_net_reset: got %b, want 1", net_reset); end
      n_cmp++; if (example_req !== 1'b0) begin n_bad++; $display("FAIL reset_example_req: got %b, want 0", example_req); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b, want 0", res_valid); end
      n_cmp++; if (res_label !== 1'b0) begin n_bad++; $display("FAIL reset_res_label: got %b, want 0", res_label); end
      n_cmp++; if (res_cnt !== 16'h0000) begin n_bad++; $display("FAIL reset_res_cnt: got %h, want 0000", res_cnt); end
      n_cmp++; if (dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d, want %0d", dbg_state, ST_IDLE); end
`ifdef SPK_TIE_FLAG_EN
      n_cmp++; if (res_tie !== 1'b0) begin n_bad++; $display("FAIL reset_res_tie: got %b, want 0", res_tie); end
`endif
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (net_reset !== 1'b1) begin n_bad++; $display("FAIL idle_net_reset: got %b, want 1", net_reset); end
      n_cmp++; if (example_req !== 1'b0) begin n_bad++; $display("FAIL idle_example_req: got %b, want 0", example_req); end
      n_cmp++; if (dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL idle_state: got %0d, want %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_basic();
      run = 1'b1; res_ready = 1'b1;
      for (int i = 0; i < WINDOW; i++) win_pat[i] = (i < 5) ? 2'b10 : (i < 8) ? 2'b01 : 2'b00;
      run_example(2'b00, -1, 1'b1);
      n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b, want 1", res_valid); end
      n_cmp++; if (net_reset !== 1'b1) begin n_bad++; $display("FAIL basic_net_reset: got %b, want 1", net_reset); end
      n_cmp++; if (res_cnt !== 16'h0503) begin n_bad++; $display("FAIL basic_cnt: got %h, want 0503", res_cnt); end
      n_cmp++; if (res_label !== 1'b1) begin n_bad++; $display("FAIL basic_label: got %b, want 1", res_label); end
   endtask

   task automatic test_tie();
      for (int i = 0; i < WINDOW; i++) win_pat[i] = (i < 4) ? 2'b11 : 2'b00;
      run_example(2'b00, -1, 1'b1);
      n_cmp++; if (res_cnt !== 16'h0404) begin n_bad++; $display("FAIL tie_cnt: got %h, want 0404", res_cnt); end
      n_cmp++; if (res_label !== 1'b0) begin n_bad++; $display("FAIL tie_label: got %b, want 0", res_label); end
`ifdef SPK_TIE_FLAG_EN
      n_cmp++; if (res_tie !== 1'b1) begin n_bad++; $display("FAIL tie_flag: got %b, want 1", res_tie); end
`endif
   endtask

   task automatic test_saturation();
      for (int i = 0; i < WINDOW; i++) win_pat[i] = 2'b11;
      run_example(2'b00, -1, 1'b1);
      n_cmp++; if (res_cnt !== 16'h0F0F) begin n_bad++; $display("FAIL sat8_cnt: got %h, want 0f0f", res_cnt); end
      n_cmp++; if (res_valid_w2 !== 1'b1) begin n_bad++; $display("FAIL sat2_valid: got %b, want 1", res_valid_w2); end
      n_cmp++; if (res_cnt_w2 !== 4'hF) begin n_bad++; $display("FAIL sat2_cnt: got %h, want f", res_cnt_w2); end
      n_cmp++; if (res_label_w2 !== 1'b0) begin n_bad++; $display("FAIL sat2_label: got %b, want 0", res_label_w2); end
   endtask

   task automatic test_period();
      for (int i = 0; i < WINDOW; i++) win_pat[i] = (i == 0) ? 2'b10 : 2'b00;
      run_example(2'b11, -1, 1'b1);
      n_cmp++; if (req_cyc - prev_req_cyc !== 18) begin n_bad++; $display("FAIL period_a: got %0d, want 18", req_cyc - prev_req_cyc); end
      n_cmp++; if (res_cnt !== 16'h0100) begin n_bad++; $display("FAIL settle_ignored_a: got %h, want 0100", res_cnt); end
      n_cmp++; if (res_label !== 1'b1) begin n_bad++; $display("FAIL period_label: got %b, want 1", res_label); end
      for (int i = 0; i < WINDOW; i++) win_pat[i] = 2'b00;
      run_example(2'b11, -1, 1'b1);
      n_cmp++; if (req_cyc - prev_req_cyc !== 18) begin n_bad++; $display("FAIL period_b: got %0d, want 18", req_cyc - prev_req_cyc); end
      n_cmp++; if (res_cnt !== 16'h0000) begin n_bad++; $display("FAIL settle_ignored_b: got %h, want 0000", res_cnt); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < WINDOW; i++) win_pat[i] = (i < 2) ? 2'b01 : (i < 8) ? 2'b10 : 2'b00;
      run_example(2'b00, -1, 1'b0);
      n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_entry: got %b, want 1", res_valid); end
      n_cmp++; if (res_cnt !== 16'h0602) begin n_bad++; $display("FAIL bp_cnt_entry: got %h, want 0602", res_cnt); end
      for (int k = 0; k < 10; k++) begin
         spk_in = 2'b11;
         @(negedge clk);
         n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: stall %0d got %b, want 1", k, res_valid); end
         n_cmp++; if (res_cnt !== 16'h0602) begin n_bad++; $display("FAIL bp_cnt: stall %0d got %h, want 0602", k, res_cnt); end
         n_cmp++; if (res_label !== 1'b1) begin n_bad++; $display("FAIL bp_label: stall %0d got %b, want 1", k, res_label); end
         n_cmp++; if (example_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_early: stall %0d got %b, want 0", k, example_req); end
      end
      res_ready = 1'b1;
      spk_in = 2'b00;
      @(negedge clk);
      n_cmp++; if (example_req !== 1'b1) begin n_bad++; $display("FAIL bp_req_after_hs: got %b, want 1", example_req); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_after_hs: got %b, want 0", res_valid); end
   endtask

   task automatic test_reset_mid();
      wait_req();
      res_ready = 1'b1;
      spk_in = 2'b00;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         spk_in = 2'b11;
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL mid_reset_state: got %0d, want %0d", dbg_state, ST_IDLE); end
      n_cmp++; if (net_reset !== 1'b1) begin n_bad++; $display("FAIL mid_reset_net_reset: got %b, want 1", net_reset); end
      n_cmp++; if (res_cnt !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_cnt: got %h, want 0000", res_cnt); end
      n_cmp++; if (res_cnt_w2 !== 4'h0) begin n_bad++; $display("FAIL mid_reset_cnt_w2: got %h, want 0", res_cnt_w2); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b, want 0", res_valid); end
      @(negedge clk);
      reset_n = 1'b1;
      spk_in = 2'b00;
      for (int i = 0; i < WINDOW; i++) win_pat[i] = (i < 3) ? 2'b01 : 2'b00;
      run_example(2'b00, -1, 1'b1);
      n_cmp++; if (res_cnt !== 16'h0003) begin n_bad++; $display("FAIL restart_cnt: got %h, want 0003", res_cnt); end
      n_cmp++; if (res_label !== 1'b0) begin n_bad++; $display("FAIL restart_label: got %b, want 0", res_label); end
   endtask

   task automatic test_run_drop();
      for (int i = 0; i < WINDOW; i++) win_pat[i] = (i < 9) ? 2'b10 : 2'b00;
      run_example(2'b00, 5, 1'b1);
      n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL drop_valid: got %b, want 1", res_valid); end
      n_cmp++; if (res_cnt !== 16'h0900) begin n_bad++; $display("FAIL drop_cnt: got %h, want 0900", res_cnt); end
      n_cmp++; if (res_label !== 1'b1) begin n_bad++; $display("FAIL drop_label: got %b, want 1", res_label); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (example_req !== 1'b0) begin n_bad++; $display("FAIL drop_req: cycle %0d got %b, want 0", k, example_req); end
         n_cmp++; if (dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL drop_state: cycle %0d got %0d, want %0d", k, dbg_state, ST_IDLE); end
         n_cmp++; if (net_reset !== 1'b1) begin n_bad++; $display("FAIL drop_net_reset: cycle %0d got %b, want 1", k, net_reset); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_saturation();
      test_period();
      test_backpressure();
      test_reset_mid();
      test_run_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by time limit, want completion");
      $fatal(1);
   end

endmodule
